// File: rtl/ps2_keycode_pkg.sv
// Shared constants for the PS/2 keycode receiver: set-2 scan codes, HID codes,
// key indices and the decode state type, plus the set-2 -> key lookup helpers.
package ps2_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    // Set-2 codes of the tracked keys (Up/Down only count after an E0 prefix)
    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_SPACE = 8'h29;
    localparam logic [7:0] PS2_ENTER = 8'h5A;

    // HID usage codes presented on the keycode output
    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;

    // Key indices; a lower index wins when the current key is released
    localparam logic [2:0] KEY_W     = 3'd0;
    localparam logic [2:0] KEY_S     = 3'd1;
    localparam logic [2:0] KEY_UP    = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_SPACE = 3'd4;
    localparam logic [2:0] KEY_ENTER = 3'd5;
    localparam logic [2:0] KEY_NONE  = 3'd7;

    // Decode state: which prefixes have been seen for the byte in flight
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_dec_e;

    // Map a resolved set-2 code (with its E0 flag) to a key index
    function automatic logic [2:0] key_index(input logic [7:0] code, input logic ext);
        logic [2:0] idx;
        idx = KEY_NONE;
        if (ext) begin
            case (code)
                PS2_UP:   idx = KEY_UP;
                PS2_DOWN: idx = KEY_DOWN;
                default:  idx = KEY_NONE;
            endcase
        end else begin
            case (code)
                PS2_W:     idx = KEY_W;
                PS2_S:     idx = KEY_S;
                PS2_SPACE: idx = KEY_SPACE;
                PS2_ENTER: idx = KEY_ENTER;
                default:   idx = KEY_NONE;
            endcase
        end
        return idx;
    endfunction

    // Map a key index to its HID code; KEY_NONE (and unused 6) give 0x00
    function automatic logic [7:0] key_hid(input logic [2:0] idx);
        logic [7:0] hid;
        case (idx)
            KEY_W:     hid = HID_W;
            KEY_S:     hid = HID_S;
            KEY_UP:    hid = HID_UP;
            KEY_DOWN:  hid = HID_DOWN;
            KEY_SPACE: hid = HID_SPACE;
            KEY_ENTER: hid = HID_ENTER;
            default:   hid = HID_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// Keycode bus between the PS/2 receiver (master) and its consumers such as
// the paddle and game-control logic (slave).
interface ps2_keycode_if;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    modport master (
        output keycode,
        output key_event,
        output frame_err
    );

    modport slave (
        input keycode,
        input key_event,
        input frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx_frame.sv
// PS/2 frame receiver: synchronises the raw PS/2 lines, detects falling clock
// edges, shifts in 11-bit frames, checks start/parity/stop and discards a
// partial frame when the keyboard clock goes quiet for WATCHDOG_CYCLES.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int              WD_W   = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic            clk_s1;
    logic            clk_s2;
    logic            clk_d;
    logic            data_s1;
    logic            data_s2;
    logic            edge_q;
    logic            data_q;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [WD_W-1:0] wd_cnt;

    // Two-flop synchronisers plus registered falling-edge strobe and its data bit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            edge_q  <= 1'b0;
            data_q  <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            edge_q  <= clk_d & ~clk_s2;
            data_q  <= data_s2;
        end
    end

    // Bit counter, shift register, frame checks and the idle-clock watchdog
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt    <= 4'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            wd_cnt     <= '0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (edge_q) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!data_q) begin
                        bit_cnt <= 4'd1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else if (bit_cnt <= 4'd8) begin
                    shift_q <= {data_q, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity_q <= data_q;
                    bit_cnt  <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (data_q && (^{shift_q, parity_q})) begin
                        byte_data  <= shift_q;
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (wd_cnt == WD_MAX) begin
                    bit_cnt   <= 4'd0;
                    wd_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WD_ONE;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard to HID keycode: decodes set-2 make/break/extended sequences,
// tracks which of the six game keys are held and presents the most recently
// pressed held key as a stable keycode level.
module ps2_keycode
    import ps2_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 50000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_keycode_if.master kc
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_dec_e   dec_state;
    ps2_dec_e   state_nx;
    logic [5:0] held;
    logic [5:0] held_nx;
    logic [2:0] current;
    logic [2:0] current_nx;
    logic       key_event_q;

    logic       do_make;
    logic       do_brk;
    logic       use_ext;
    logic [2:0] key;

    ps2_rx_frame #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_rx (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    // Resolve each received byte through the prefix FSM and update held keys
    always_comb begin
        state_nx   = dec_state;
        held_nx    = held;
        current_nx = current;
        do_make    = 1'b0;
        do_brk     = 1'b0;
        use_ext    = 1'b0;
        if (rx_valid) begin
            case (dec_state)
                IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_nx = EXT;
                    end else if (rx_byte == PS2_BRK) begin
                        state_nx = BRK;
                    end else begin
                        do_make  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        state_nx = EXT_BRK;
                    end else begin
                        do_make  = 1'b1;
                        use_ext  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    do_brk   = 1'b1;
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    do_brk   = 1'b1;
                    use_ext  = 1'b1;
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        key = key_index(rx_byte, use_ext);
        if (key != KEY_NONE) begin
            if (do_make) begin
                held_nx[key] = 1'b1;
                current_nx   = key;
            end else if (do_brk && held[key]) begin
                held_nx[key] = 1'b0;
                if (current == key) begin
                    current_nx = KEY_NONE;
                    for (int i = 5; i >= 0; i--) begin
                        if (held_nx[3'(i)]) begin
                            current_nx = 3'(i);
                        end
                    end
                end
            end
        end
    end

    // Decode state, held mask, current key and the keycode-change pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dec_state   <= IDLE;
            held        <= 6'b000000;
            current     <= KEY_NONE;
            key_event_q <= 1'b0;
        end else begin
            dec_state   <= state_nx;
            held        <= held_nx;
            current     <= current_nx;
            key_event_q <= (key_hid(current_nx) != key_hid(current));
        end
    end

    assign kc.keycode   = key_hid(current);
    assign kc.key_event = key_event_q;
    assign kc.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// Testbench for ps2_keycode: bit-bangs PS/2 frames, keeps a key-list model of
// what the keyboard state must be, and compares every cycle against the DUT.
`timescale 1ns/1ps
module tb_ps2_keycode;

    localparam int WD   = 100;
    localparam int HALF = 8;

    logic Clk      = 1'b0;
    logic Reset_n  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keycode_if kc_if ();

    ps2_keycode #(
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kc       (kc_if)
    );

    always #10 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;

    // Model: prefix flags, held flags per key, most recent held key (7 = none)
    bit         m_ext;
    bit         m_brk;
    bit         m_held [6];
    logic [2:0] m_cur = 3'd7;
    logic [7:0] exp_kc  = 8'h00;
    logic       exp_ev  = 1'b0;
    logic       exp_err = 1'b0;

    bit cmp_en    = 1'b0;
    bit wd_window = 1'b0;
    int wd_errs   = 0;
    int ev_count  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] keyOf(input logic [7:0] b, input bit ext);
        if (ext) begin
            if (b == 8'h75) return 3'd2;
            if (b == 8'h72) return 3'd3;
            return 3'd7;
        end
        case (b)
            8'h1D:   return 3'd0;
            8'h1B:   return 3'd1;
            8'h29:   return 3'd4;
            8'h5A:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [7:0] hidOf(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h1A;
            3'd1:    return 8'h16;
            3'd2:    return 8'h52;
            3'd3:    return 8'h51;
            3'd4:    return 8'h2C;
            3'd5:    return 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        m_ext = 1'b0;
        m_brk = 1'b0;
        for (int i = 0; i < 6; i++) m_held[i] = 1'b0;
        m_cur   = 3'd7;
        exp_kc  = 8'h00;
        exp_ev  = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic [2:0] k;
        logic [7:0] new_kc;
        if (!m_brk && !m_ext && b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            k = keyOf(b, m_ext);
            if (k != 3'd7) begin
                if (!m_brk) begin
                    m_held[k] = 1'b1;
                    m_cur     = k;
                end else if (m_held[k]) begin
                    m_held[k] = 1'b0;
                    if (m_cur == k) begin
                        m_cur = 3'd7;
                        for (int i = 0; i < 6 && m_cur == 3'd7; i++)
                            if (m_held[i]) m_cur = 3'(i);
                    end
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        new_kc = hidOf(m_cur);
        exp_ev = (new_kc != exp_kc);
        exp_kc = new_kc;
    endtask

    // One PS/2 bit; the expectation updates land on the cycles the outputs must move
    task automatic clockBit(input bit d, input bit err_here, input bit done_here, input logic [7:0] b);
        ps2_data = d;
        repeat (HALF) @(negedge Clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge Clk);
        exp_err = err_here;
        @(negedge Clk);
        exp_err = 1'b0;
        if (done_here) modelByte(b);
        @(negedge Clk);
        exp_ev = 1'b0;
        repeat (HALF - 5) @(negedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bit          bad;
        bad       = bad_par | bad_stop;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < 11; i++)
            clockBit(bits[4'(i)], (i == 10) && bad, (i == 10) && !bad, b);
        repeat (4) @(negedge Clk);
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(posedge Clk) begin
        #1;
        if (cmp_en) begin
            checkOutput("keycode", 32'(kc_if.keycode), 32'(exp_kc));
            checkOutput("key_event", 32'(kc_if.key_event), 32'(exp_ev));
            if (wd_window) begin
                if (kc_if.frame_err) wd_errs++;
            end else begin
                checkOutput("frame_err", 32'(kc_if.frame_err), 32'(exp_err));
            end
            if (kc_if.key_event) ev_count++;
        end
    end

    logic [7:0] pool [12];
    logic [7:0] rb;
    int         sel;
    int         r;
    int         ev0;

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'h5A, 8'hAA, 8'hFA, 8'hE1, 8'h00};
        modelReset();
        repeat (3) @(negedge Clk);
        checkOutput("reset_keycode", 32'(kc_if.keycode), 32'h00);
        checkOutput("reset_key_event", 32'(kc_if.key_event), 32'h0);
        checkOutput("reset_frame_err", 32'(kc_if.frame_err), 32'h0);
        Reset_n = 1'b1;
        cmp_en  = 1'b1;
        repeat (4) @(negedge Clk);

        // W press and release
        ev0 = ev_count;
        applyStimulus(8'h1D, 0, 0);
        checkOutput("w_make", 32'(kc_if.keycode), 32'h1A);
        checkOutput("w_make_events", 32'(ev_count - ev0), 32'd1);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1D, 0, 0);
        checkOutput("w_break", 32'(kc_if.keycode), 32'h00);
        checkOutput("w_break_events", 32'(ev_count - ev0), 32'd2);

        // Up then S, Up released while S is current
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        checkOutput("up_make", 32'(kc_if.keycode), 32'h52);
        applyStimulus(8'h1B, 0, 0);
        checkOutput("s_make", 32'(kc_if.keycode), 32'h16);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        checkOutput("up_break_keeps_s", 32'(kc_if.keycode), 32'h16);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1B, 0, 0);
        checkOutput("s_break", 32'(kc_if.keycode), 32'h00);

        // W and Space held, Space repeats, Space released
        applyStimulus(8'h1D, 0, 0);
        applyStimulus(8'h29, 0, 0);
        checkOutput("space_make", 32'(kc_if.keycode), 32'h2C);
        ev0 = ev_count;
        for (int i = 0; i < 3; i++) applyStimulus(8'h29, 0, 0);
        checkOutput("typematic_no_event", 32'(ev_count - ev0), 32'd0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h29, 0, 0);
        checkOutput("space_break_falls_to_w", 32'(kc_if.keycode), 32'h1A);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1D, 0, 0);

        // Rejected frames leave the keycode alone
        applyStimulus(8'h1D, 1, 0);
        checkOutput("bad_parity_ignored", 32'(kc_if.keycode), 32'h00);
        applyStimulus(8'h1D, 0, 1);
        checkOutput("bad_stop_ignored", 32'(kc_if.keycode), 32'h00);
        clockBit(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (4) @(negedge Clk);

        // Partial frame abandoned by the watchdog, then a clean Enter
        clockBit(1'b0, 0, 0, 8'h00);
        clockBit(1'b1, 0, 0, 8'h00);
        clockBit(1'b0, 0, 0, 8'h00);
        clockBit(1'b1, 0, 0, 8'h00);
        clockBit(1'b1, 0, 0, 8'h00);
        wd_errs   = 0;
        wd_window = 1'b1;
        repeat (WD + 30) @(negedge Clk);
        wd_window = 1'b0;
        checkOutput("watchdog_err_count", 32'(wd_errs), 32'd1);
        applyStimulus(8'h5A, 0, 0);
        checkOutput("enter_after_watchdog", 32'(kc_if.keycode), 32'h28);

        // Down current, reset in the middle of a frame, keypad 2 ignored
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h72, 0, 0);
        checkOutput("down_make", 32'(kc_if.keycode), 32'h51);
        ev0 = ev_count;
        clockBit(1'b0, 0, 0, 8'h00);
        clockBit(1'b1, 0, 0, 8'h00);
        clockBit(1'b0, 0, 0, 8'h00);
        Reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midframe_reset_keycode", 32'(kc_if.keycode), 32'h00);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("midframe_reset_no_event", 32'(ev_count - ev0), 32'd0);
        applyStimulus(8'h72, 0, 0);
        checkOutput("keypad2_unmapped", 32'(kc_if.keycode), 32'h00);

        // Randomized byte stream with occasional corrupted frames
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 11);
            rb  = pool[sel];
            if (sel == 11) rb = 8'($urandom);
            r = $urandom_range(0, 11);
            applyStimulus(rb, r == 0, r == 1);
        end

        repeat (10) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
